// File: rtl/simplecpu_pkg.sv
// simplecpu_pkg: shared widths, memory FSM states and parity helper for the simplecpu memory path
package simplecpu_pkg;
    localparam int DW_DEF = 9;
    localparam int AW_DEF = 6;
    typedef enum logic [1:0] {IDLE, WAIT_ST, DONE} state_t;
    function automatic logic parity(input logic [63:0] v);
        return ^v;
    endfunction
endpackage

// File: rtl/sync_mem_array.sv
// sync_mem_array: DEPTH-word register array, one synchronous write port, one asynchronous read port
module sync_mem_array #(
    parameter int W = 9,
    parameter int DEPTH = 64,
    parameter int IW = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [IW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];
    // storage write; contents deliberately survive reset
    always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/sync_mem.sv
// sync_mem: clocked CPU memory with READY handshake, read wait states and program-load port
// Optional per-word even parity with PERR reporting when SYNC_MEM_PARITY_EN is defined.
module sync_mem import simplecpu_pkg::*; #(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF,
    parameter int DEPTH = 64,
    parameter int WAIT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          READ,
    input  logic          WRITE,
    input  logic [AW-1:0] A,
    input  logic [DW-1:0] DATA,
    output logic [DW-1:0] D,
    output logic          READY,
    output logic          PERR,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [DW-1:0] load_data,
    input  logic          load_par_inv
);
`ifdef SYNC_MEM_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int W = DW + PB;
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] LIM = DEPTH[AW:0];
    localparam logic [2:0] WCNT = WAIT[2:0];

    state_t state, state_nx;
    logic [2:0] cnt;
    logic [AW-1:0] alat, waddr;
    logic [W-1:0] wdata, rdata;
    logic [DW-1:0] rd_val;
    logic idle, acc_rd, acc_wr, is_rd, we, rd_ok, rd_perr;

    assign idle = state == IDLE;
    assign acc_wr = idle & ~load_en & WRITE;
    assign acc_rd = idle & ~load_en & READ & ~WRITE;
    assign waddr = load_en ? load_addr : A;
    assign we = idle & (load_en | WRITE) & ({1'b0, waddr} < LIM);
    assign rd_ok = {1'b0, alat} < LIM;
    assign rd_val = rd_ok ? rdata[DW-1:0] : '0;

`ifdef SYNC_MEM_PARITY_EN
    assign wdata = load_en ? {parity(64'(load_data)) ^ load_par_inv, load_data} : {parity(64'(DATA)), DATA};
    assign rd_perr = rd_ok & (rdata[DW] != parity(64'(rdata[DW-1:0])));
`else
    logic par_inv_unused;
    assign par_inv_unused = load_par_inv;
    assign wdata = load_en ? load_data : DATA;
    assign rd_perr = 1'b0;
`endif

    sync_mem_array #(.W(W), .DEPTH(DEPTH), .IW(IW)) u_array (
        .clk   (clk),
        .we    (we),
        .waddr (waddr[IW-1:0]),
        .wdata (wdata),
        .raddr (alat[IW-1:0]),
        .rdata (rdata)
    );

    // state register
    always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nx;

    // next state: writes and zero-wait reads go straight to DONE, reads drain the counter first
    always_comb begin
        state_nx = IDLE;
        if (idle) state_nx = (acc_wr || (acc_rd && WCNT == 3'd0)) ? DONE : acc_rd ? WAIT_ST : IDLE;
        else if (state == WAIT_ST) state_nx = cnt == 3'd1 ? DONE : WAIT_ST;
    end

    // request latch, wait counter and the registered D/READY/PERR leaving DONE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {cnt, alat, is_rd, D, READY, PERR} <= '0;
        end else begin
            READY <= state == DONE;
            PERR <= (state == DONE) & is_rd & rd_perr;
            if (state == DONE && is_rd) D <= rd_val;
            if (acc_rd || acc_wr) begin
                alat <= A;
                is_rd <= acc_rd;
                cnt <= acc_rd ? WCNT : 3'd0;
            end else if (state == WAIT_ST) begin
                cnt <= cnt - 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_sync_mem.sv
// tb_sync_mem: scoreboard bench for sync_mem, one WAIT=2/DEPTH=48 and one WAIT=0/DEPTH=64 instance
module tb_sync_mem;
    logic clk = 0, rst_n = 0, rd = 0, wr = 0, load_en = 0, load_par_inv = 0;
    logic [5:0] a = '0, load_addr = '0;
    logic [8:0] data = '0, load_data = '0;
    logic [8:0] d2, d0;
    logic ready2, ready0, perr2, perr0;
    int cyc = 0, checks = 0, failures = 0;

`ifdef SYNC_MEM_PARITY_EN
    localparam logic EP = 1'b1;
`else
    localparam logic EP = 1'b0;
`endif

    typedef struct {
        int         cyc;
        logic [8:0] d;
        logic       p;
        int         tag;
    } exp_t;
    exp_t q2[$], q0[$];

    sync_mem #(.DW(9), .AW(6), .DEPTH(48), .WAIT(2)) u2 (
        .clk(clk), .rst_n(rst_n), .READ(rd), .WRITE(wr), .A(a), .DATA(data),
        .D(d2), .READY(ready2), .PERR(perr2), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .load_par_inv(load_par_inv)
    );

    sync_mem #(.DW(9), .AW(6), .DEPTH(64), .WAIT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .READ(rd), .WRITE(wr), .A(a), .DATA(data),
        .D(d0), .READY(ready0), .PERR(perr0), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .load_par_inv(load_par_inv)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic pop_cmp(input int u, input logic [8:0] d, input logic p);
        exp_t e;
        checks++;
        if ((u == 2 ? q2.size() : q0.size()) == 0) begin
            failures++;
            $display("FAIL unexpected_ready_u%0d cyc=%0d got d=%h perr=%b want no READY", u, cyc, d, p);
            return;
        end
        if (u == 2) e = q2.pop_front();
        else e = q0.pop_front();
        if (e.cyc != cyc || e.d !== d || e.p !== p) begin
            failures++;
            $display("FAIL ready_u%0d_t%0d got cyc=%0d d=%h perr=%b want cyc=%0d d=%h perr=%b",
                     u, e.tag, cyc, d, p, e.cyc, e.d, e.p);
        end
    endtask

    always @(negedge clk) begin
        if (ready2 === 1'b1) pop_cmp(2, d2, perr2);
        if (ready0 === 1'b1) pop_cmp(0, d0, perr0);
    end

    task automatic chk(input string nm, input logic [8:0] got, input logic [8:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic ld(input logic [5:0] ad, input logic [8:0] dt, input logic inv);
        @(negedge clk);
        load_en = 1; load_addr = ad; load_data = dt; load_par_inv = inv;
        @(negedge clk);
        load_en = 0; load_par_inv = 0;
    endtask

    task automatic req(input int tag, input logic r, input logic w, input logic [5:0] ad,
                       input logic [8:0] dt, input logic [8:0] e2, input logic [8:0] e0,
                       input logic ep, input logic ld_busy);
        logic rop;
        @(negedge clk);
        rd = r; wr = w; a = ad; data = dt;
        @(posedge clk); #1;
        rd = 0; wr = 0;
        rop = r & ~w;
        q2.push_back('{cyc + (rop ? 3 : 1), e2, ep, tag});
        q0.push_back('{cyc + 1, e0, ep, tag});
        if (ld_busy) begin
            load_en = 1; load_addr = 6; load_data = 9'h1FF;
            @(posedge clk); #1;
            load_en = 0;
        end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d want finish before time limit", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1;
        chk("rst_d2", d2, 9'h000);
        chk("rst_ready2", {8'h0, ready2}, 9'h000);
        chk("rst_perr2", {8'h0, perr2}, 9'h000);
        chk("rst_d0", d0, 9'h000);
        chk("rst_ready0", {8'h0, ready0}, 9'h000);
        chk("rst_perr0", {8'h0, perr0}, 9'h000);
        ld(5, 9'h1A3, 0);
        ld(6, 9'h0CC, 0);
        ld(18, 9'h012, 0);
        ld(9, 9'h001, 1);
        req(1, 1, 0, 5, 9'h000, 9'h1A3, 9'h1A3, 0, 0);
        req(2, 0, 1, 7, 9'h055, 9'h1A3, 9'h1A3, 0, 0);
        req(3, 1, 0, 7, 9'h000, 9'h055, 9'h055, 0, 0);
        req(4, 1, 1, 3, 9'h0F0, 9'h055, 9'h055, 0, 0);
        req(5, 1, 0, 3, 9'h000, 9'h0F0, 9'h0F0, 0, 0);
        req(6, 0, 1, 50, 9'h1EE, 9'h0F0, 9'h0F0, 0, 0);
        req(7, 1, 0, 50, 9'h000, 9'h000, 9'h1EE, 0, 0);
        req(8, 1, 0, 18, 9'h000, 9'h012, 9'h012, 0, 0);
        @(negedge clk);
        wr = 1; a = 2; data = 9'h111; load_en = 1; load_addr = 4; load_data = 9'h0AA;
        @(posedge clk); #1;
        load_en = 0;
        @(posedge clk); #1;
        wr = 0;
        q2.push_back('{cyc + 1, 9'h012, 1'b0, 9});
        q0.push_back('{cyc + 1, 9'h012, 1'b0, 9});
        repeat (5) @(negedge clk);
        req(10, 1, 0, 4, 9'h000, 9'h0AA, 9'h0AA, 0, 0);
        req(11, 1, 0, 2, 9'h000, 9'h111, 9'h111, 0, 0);
        req(12, 1, 0, 5, 9'h000, 9'h1A3, 9'h1A3, 0, 1);
        req(13, 1, 0, 6, 9'h000, 9'h0CC, 9'h0CC, 0, 0);
        req(14, 1, 0, 9, 9'h000, 9'h001, 9'h001, EP, 0);
        @(negedge clk);
        rd = 1; a = 5;
        @(posedge clk); #1;
        rd = 0;
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        chk("abort_d2", d2, 9'h000);
        chk("abort_ready2", {8'h0, ready2}, 9'h000);
        chk("abort_d0", d0, 9'h000);
        chk("abort_ready0", {8'h0, ready0}, 9'h000);
        repeat (4) @(negedge clk);
        @(negedge clk);
        wr = 1; a = 11; data = 9'h077;
        @(posedge clk); #1;
        wr = 0;
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        repeat (3) @(negedge clk);
        req(15, 1, 0, 11, 9'h000, 9'h077, 9'h077, 0, 0);
        repeat (4) @(negedge clk);
        checks++;
        if (q2.size() != 0 || q0.size() != 0) begin
            failures++;
            $display("FAIL pending_ready got pending=%0d/%0d want 0/0", q2.size(), q0.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sync_mem.md
# sync_mem

Parametrised, clocked successor to the CPU-facing program/data memory model. It keeps the simplecpu strobe-style bus (READ, WRITE, A, DATA in, D out) and adds a READY handshake, a configurable number of read wait states, a depth independent of the address width, and a side port for loading a program. It sits between `simplecpu` and the top-level test harness, and lets the CPU be exercised against slow memory.

## Interface
- `DW`, 9: data word width.
- `AW`, 6: address width.
- `DEPTH`, 64: implemented words, 1..2**AW.
- `WAIT`, 1: read wait states, 0..7.
- `clk` input 1: single clock, all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `READ` input 1: read strobe from the CPU.
- `WRITE` input 1: write strobe from the CPU.
- `A` input AW: word address.
- `DATA` input DW: write data from the CPU.
- `D` output DW: read data to the CPU, registered.
- `READY` output 1: one-cycle completion pulse.
- `PERR` output 1: parity error, valid with READY on reads.
- `load_en` input 1: program-load write enable.
- `load_addr` input AW: program-load address.
- `load_data` input DW: program-load data.
- `load_par_inv` input 1: store inverted parity on a load (error injection).

## Operation
- FSM has three states:
  - IDLE: accepts requests.
  - WAIT: counts read wait states.
  - DONE: READY=1 for exactly one cycle, then IDLE.
- Acceptance happens only on a rising edge in IDLE with READ or WRITE high.
- Priority in IDLE: load_en > WRITE > READ. With load_en high the load commits and the request is not accepted; it is retried the next cycle if the strobe is still held.
- Write path:
  - `mem[A] <= DATA` on the accepting edge.
  - Next state is DONE, regardless of WAIT.
- Read path:
  - A is latched and the counter loads WAIT.
  - With WAIT=0, the next state is DONE.
  - Otherwise the FSM enters WAIT and the counter decrements each edge. The edge on which the counter equals 0 registers D and moves to DONE.
- READ and WRITE both high: treated as a write; the read is dropped.
- The CPU must deassert its strobe in the cycle it sees READY. A strobe still high in the following IDLE cycle is a new request.
- Addresses at or above DEPTH:
  - A read returns 0 with PERR=0.
  - A write is discarded, but READY still pulses.
  - A load to such an address is discarded.
- Load port is accepted only in IDLE. In WAIT or DONE, load_en is ignored; the load source must hold load_en until the FSM is back in IDLE.
- D holds the last completed read value until the next read completes.
- Reset:
  - State IDLE, counter 0, D=0, READY=0, PERR=0.
  - Memory contents are not cleared.
- Reset during WAIT or DONE abandons the transaction and READY is not issued. A write committed before reset remains in memory.

## Timing
- Write: accept edge k, READY high during cycle k+1 to k+2.
- Read: accept edge k, D valid and READY high from edge k+WAIT+1 for one cycle.
- Maximum request rate: a write every 2 cycles; a read every WAIT+2 cycles.
- Load: single edge, no READY.

## Configuration
- `SYNC_MEM_PARITY_EN` defined:
  - Each word stores an extra even-parity bit over its DW bits.
  - The stored bit is generated on CPU writes. On loads it is generated and XORed with load_par_inv.
  - On a read, a mismatch sets PERR=1 in the DONE cycle; PERR is 0 in all other cycles.
- Undefined: no parity storage, PERR tied 0, load_par_inv ignored.

## Structure
- Shared package `simplecpu_pkg`:
  - default DW=9 and AW=6 constants;
  - FSM state enum {IDLE, WAIT, DONE};
  - a parity function.
- One sub-module, `sync_mem_array`: a DEPTH x (DW + parity) register array with one synchronous write port and one asynchronous read port. Write ports are muxed between load and CPU in the parent.
- The FSM, wait counter, D/READY/PERR registers and range check live in `sync_mem`.

## Test plan
- Reset release: all outputs 0, FSM in IDLE; preload via load port of mem[5]=9'h1A3 succeeds.
- WAIT=2, READ with A=5: READY and D=9'h1A3 exactly 3 edges after acceptance, for one cycle.
- WRITE A=7 DATA=9'h055, then READ A=7 with WAIT=0: write READY 1 edge after acceptance; read returns 9'h055 1 edge after acceptance.
- READ and WRITE together at A=3, DATA=9'h0F0: treated as a write, mem[3]=9'h0F0; an immediate read returns 9'h0F0.
- DEPTH=48, READ A=50 returns 0 with READY; WRITE A=50 leaves mem[50-32 alias]=unchanged; rst_n low during WAIT gives no READY and D=0.
- With `SYNC_MEM_PARITY_EN`: load mem[9]=9'h001 with load_par_inv=1, then READ A=9 gives PERR=1 and D=9'h001; the same test without the macro gives PERR=0.
